// File: rtl/fps_if.sv
// Handshake and phase-line bundle between the F-PS sequencer and the F-PM datapath.
interface fps_if;
    logic start, af_sf, mw_mf, dw_df, ad_sd, nrf;
    logic g, fic_end, ok, nz, fint;
    logic f2_, f4_, f5_, f6_, f7_, f8_, f10_;
    logic f9, f13;
    logic strob_fp, strob2_fp, _0_f;
    logic busy, done, abort, ovf;

    modport master (
        output start, af_sf, mw_mf, dw_df, ad_sd, nrf,
        output g, fic_end, ok, nz, fint,
        input  f2_, f4_, f5_, f6_, f7_, f8_, f10_,
        input  f9, f13,
        input  strob_fp, strob2_fp, _0_f,
        input  busy, done, abort, ovf
    );

    modport slave (
        input  start, af_sf, mw_mf, dw_df, ad_sd, nrf,
        input  g, fic_end, ok, nz, fint,
        output f2_, f4_, f5_, f6_, f7_, f8_, f10_,
        output f9, f13,
        output strob_fp, strob2_fp, _0_f,
        output busy, done, abort, ovf
    );
endinterface

// File: rtl/fps.sv
// F-PS sequencer: walks the F-PM datapath phases, issues per-phase strobes,
// loops shift/iteration phases on datapath flags and reports done/abort.
module fps #(
    parameter int PH_TICKS = 4,
    parameter int LOOP_MAX = 63
) (
    input logic  __clk,
    input logic  clr_,
    fps_if.slave bus
);
    localparam int KW = $clog2(PH_TICKS);
    localparam logic [KW-1:0] K_LAST = KW'(PH_TICKS - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [5:0]    L_MAX  = 6'(LOOP_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_F2, S_F4, S_F5, S_F6,
        S_F7, S_F8, S_F9, S_F10, S_F13
    } st_t;

    st_t           r_st, w_st, w_nx;
    logic [KW-1:0] r_k, w_k;
    logic [5:0]    r_loop, w_loop;
    logic          r_armed, w_armed;
    logic          r_ovf, w_ovf;
    logic          w_rep, w_done, w_abort, w_clr;
    logic          r_f2_, r_f4_, r_f5_, r_f6_, r_f7_, r_f8_, r_f10_;
    logic          r_f9, r_f13;
    logic          r_strob, r_strob2, r_clr;
    logic          r_busy, r_done, r_abort;

    always_comb begin
        w_st    = r_st;
        w_k     = r_k;
        w_loop  = r_loop;
        w_armed = r_armed;
        w_ovf   = r_ovf;
        w_done  = 1'b0;
        w_abort = 1'b0;
        w_clr   = 1'b0;
        w_rep   = 1'b0;
        w_nx    = S_IDLE;

        unique case (r_st)
            S_F2: begin
                if (bus.mw_mf | bus.dw_df) w_nx = S_F4;
                else if (bus.af_sf)        w_nx = S_F5;
                else if (bus.ad_sd)        w_nx = S_F7;
                else if (bus.nrf)          w_nx = S_F10;
                else                       w_nx = S_IDLE;
            end
            S_F4:  w_nx = S_F6;
            S_F5:  w_nx = bus.g ? S_F9 : S_F8;
            S_F6: begin
                w_rep = !bus.fic_end;
                w_nx  = bus.dw_df ? S_F9 : S_F10;
            end
            S_F7:  w_nx = S_F10;
            S_F8: begin
                w_rep = !bus.fic_end;
                w_nx  = S_F7;
            end
            S_F9:  w_nx = S_F10;
            S_F10: begin
                w_rep = bus.nz & !bus.ok;
                w_nx  = S_F13;
            end
            S_F13:   w_nx = S_IDLE;
            default: w_nx = S_IDLE;
        endcase

        // start is edge-qualified: it must be seen low in IDLE to re-arm
        if (r_st == S_IDLE) begin
            if (!bus.start) begin
                w_armed = 1'b1;
            end else if (r_armed) begin
                w_armed = 1'b0;
                w_st    = S_F2;
                w_k     = '0;
                w_loop  = '0;
                w_ovf   = 1'b0;
                w_clr   = 1'b1;
            end
        end else if (r_k != K_LAST) begin
            w_k = r_k + K_ONE;
        end else begin
            w_k = '0;
            if (bus.fint) begin
                w_st    = S_IDLE;
                w_loop  = '0;
                w_abort = 1'b1;
            end else if (w_rep && (r_loop != L_MAX)) begin
                w_loop = r_loop + 6'd1;
            end else begin
                if (w_rep) w_ovf = 1'b1;
                w_st    = w_nx;
                w_loop  = '0;
                w_done  = (r_st == S_F13);
                w_abort = (r_st == S_F2) && (w_nx == S_IDLE);
            end
        end
    end

    always_ff @(posedge __clk or negedge clr_) begin
        if (!clr_) begin
            r_st     <= S_IDLE;
            r_k      <= '0;
            r_loop   <= '0;
            r_armed  <= 1'b1;
            r_ovf    <= 1'b0;
            r_f2_    <= 1'b1;
            r_f4_    <= 1'b1;
            r_f5_    <= 1'b1;
            r_f6_    <= 1'b1;
            r_f7_    <= 1'b1;
            r_f8_    <= 1'b1;
            r_f10_   <= 1'b1;
            r_f9     <= 1'b0;
            r_f13    <= 1'b0;
            r_strob  <= 1'b0;
            r_strob2 <= 1'b0;
            r_clr    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_st     <= w_st;
            r_k      <= w_k;
            r_loop   <= w_loop;
            r_armed  <= w_armed;
            r_ovf    <= w_ovf;
            r_f2_    <= (w_st != S_F2);
            r_f4_    <= (w_st != S_F4);
            r_f5_    <= (w_st != S_F5);
            r_f6_    <= (w_st != S_F6);
            r_f7_    <= (w_st != S_F7);
            r_f8_    <= (w_st != S_F8);
            r_f10_   <= (w_st != S_F10);
            r_f9     <= (w_st == S_F9);
            r_f13    <= (w_st == S_F13);
            r_strob  <= (w_st != S_IDLE) && (w_k == K_ONE);
            r_strob2 <= (w_st != S_IDLE) && (w_k == K_LAST);
            r_clr    <= w_clr;
            r_busy   <= (w_st != S_IDLE);
            r_done   <= w_done;
            r_abort  <= w_abort;
        end
    end

    assign bus.f2_       = r_f2_;
    assign bus.f4_       = r_f4_;
    assign bus.f5_       = r_f5_;
    assign bus.f6_       = r_f6_;
    assign bus.f7_       = r_f7_;
    assign bus.f8_       = r_f8_;
    assign bus.f10_      = r_f10_;
    assign bus.f9        = r_f9;
    assign bus.f13       = r_f13;
    assign bus.strob_fp  = r_strob;
    assign bus.strob2_fp = r_strob2;
    assign bus._0_f      = r_clr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.abort     = r_abort;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fps.sv
// Directed bench for the F-PS sequencer: phase traces, timing,
// loop overflow, interrupt abort, reset and start re-arming.
module tb_fps;
    logic clk = 1'b0;
    logic clr_ = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    fps_if ifc ();

    fps #(.PH_TICKS(4), .LOOP_MAX(63)) dut (
        .__clk (clk),
        .clr_  (clr_),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: got %0d want %0d", tag, o, e);
        end
    endtask

    task automatic chks(input string tag, input string o, input string e);
        nvec++;
        assert (o == e) else begin
            nerr++;
            $error("FAIL %s: got %s want %s", tag, o, e);
        end
    endtask

    function automatic int ph_cnt();
        return int'(!ifc.f2_) + int'(!ifc.f4_) + int'(!ifc.f5_)
             + int'(!ifc.f6_) + int'(!ifc.f7_) + int'(!ifc.f8_)
             + int'(!ifc.f10_) + int'(ifc.f9) + int'(ifc.f13);
    endfunction

    function automatic int ph_code();
        int c = 0;
        if (!ifc.f2_)  c = 2;
        if (!ifc.f4_)  c = 4;
        if (!ifc.f5_)  c = 5;
        if (!ifc.f6_)  c = 6;
        if (!ifc.f7_)  c = 7;
        if (!ifc.f8_)  c = 8;
        if (ifc.f9)    c = 9;
        if (!ifc.f10_) c = 10;
        if (ifc.f13)   c = 13;
        return (ph_cnt() > 1) ? 99 : c;
    endfunction

    // One phase name is logged per strob_fp, so repeats show up individually.
    task automatic run(input int fic_n, input int fint_ph, input bit noise,
                       input bit hold, input int budget,
                       output string tr, output int cyc, output bit gd,
                       output bit ga, output int nclr, output int viol);
        int rep = 0;
        int last = -1;
        int p;
        tr = "";
        cyc = 0;
        gd = 1'b0;
        ga = 1'b0;
        nclr = 0;
        viol = 0;
        ifc.fic_end = 1'b0;
        ifc.fint = 1'b0;
        ifc.start = 1'b0;
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        while (!gd && !ga && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) ifc.start = 1'b0;
            ifc.fint = 1'b0;
            if (ifc._0_f) nclr++;
            if ((ifc.busy && ph_cnt() != 1) || (!ifc.busy && ph_cnt() != 0))
                viol++;
            if (ifc.strob_fp) begin
                p = ph_code();
                rep = (p == last) ? rep + 1 : 1;
                last = p;
                tr = {tr, $sformatf("%0d,", p)};
                ifc.fic_end = (rep >= fic_n);
                if (noise) ifc.fint = 1'b1;
            end
            if (ifc.strob2_fp && ph_code() == fint_ph) ifc.fint = 1'b1;
            gd = ifc.done;
            ga = ifc.abort;
        end
        ifc.fint = 1'b0;
    endtask

    initial begin
        string tr;
        string exp_tr;
        int    cyc;
        bit    gd;
        bit    ga;
        int    nclr;
        int    viol;
        int    cnt;

        {ifc.start, ifc.af_sf, ifc.mw_mf, ifc.dw_df, ifc.ad_sd, ifc.nrf} = '0;
        {ifc.g, ifc.fic_end, ifc.nz, ifc.fint} = '0;
        ifc.ok = 1'b1;

        #12;
        chk("rst_lo_lines", {ifc.f2_, ifc.f4_, ifc.f5_, ifc.f6_, ifc.f7_,
                             ifc.f8_, ifc.f10_}, 7'h7F);
        chk("rst_hi_lines", {ifc.f9, ifc.f13}, 2'b00);
        chk("rst_flags", {ifc.strob_fp, ifc.strob2_fp, ifc._0_f, ifc.busy,
                          ifc.done, ifc.abort, ifc.ovf}, 7'h00);
        clr_ = 1'b1;
        @(posedge clk);
        #1;

        // MF: F6 ends on the third pass
        ifc.mw_mf = 1'b1;
        run(3, 0, 1'b0, 1'b0, 200, tr, cyc, gd, ga, nclr, viol);
        chks("mf_trace", tr, "2,4,6,6,6,10,13,");
        chk("mf_done", gd, 1'b1);
        chk("mf_abort", ga, 1'b0);
        chk("mf_latency", cyc, 29);
        chk("mf_clr_cnt", nclr, 1);
        chk("mf_onehot", viol, 0);
        @(posedge clk);
        #1;
        chk("mf_done_1cyc", {ifc.done, ifc.busy}, 2'b00);
        ifc.mw_mf = 1'b0;

        // AF g=1, fint pulses off the strob2 tick, start held through
        ifc.af_sf = 1'b1;
        ifc.g = 1'b1;
        run(1, 0, 1'b1, 1'b1, 200, tr, cyc, gd, ga, nclr, viol);
        chks("af_g_trace", tr, "2,5,9,10,13,");
        chk("af_g_done", {gd, ga}, 2'b10);
        chk("af_g_latency", cyc, 21);
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ifc.busy || ifc._0_f) cnt++;
        end
        chk("hold_no_retrig", cnt, 0);
        ifc.start = 1'b0;

        // AF g=0: F8 ends on the second pass
        ifc.g = 1'b0;
        run(2, 0, 1'b0, 1'b0, 200, tr, cyc, gd, ga, nclr, viol);
        chks("af_s_trace", tr, "2,5,8,8,7,10,13,");
        chk("af_s_done", {gd, ga}, 2'b10);
        chk("af_s_onehot", viol, 0);

        // fint at strob2 of the first F8
        run(5, 8, 1'b0, 1'b0, 200, tr, cyc, gd, ga, nclr, viol);
        chks("fint_trace", tr, "2,5,8,");
        chk("fint_abort", {gd, ga}, 2'b01);
        chk("fint_latency", cyc, 13);
        chk("fint_f8_off", {ifc.f8_, ifc.busy}, 2'b10);
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ifc.strob_fp || ifc.abort) cnt++;
        end
        chk("fint_quiet", cnt, 0);
        ifc.af_sf = 1'b0;

        // no class bit set
        run(1, 0, 1'b0, 1'b0, 50, tr, cyc, gd, ga, nclr, viol);
        chks("none_trace", tr, "2,");
        chk("none_abort", {gd, ga}, 2'b01);
        chk("none_latency", cyc, 5);

        // DF with fic_end never: forced exit after 64 F6 passes
        ifc.dw_df = 1'b1;
        exp_tr = "2,4,";
        repeat (64) exp_tr = {exp_tr, "6,"};
        exp_tr = {exp_tr, "9,10,13,"};
        run(1000, 0, 1'b0, 1'b0, 400, tr, cyc, gd, ga, nclr, viol);
        chks("df_ovf_trace", tr, exp_tr);
        chk("df_ovf_done", {gd, ga}, 2'b10);
        chk("df_ovf_flag", ifc.ovf, 1'b1);
        chk("df_ovf_latency", cyc, 277);
        ifc.dw_df = 1'b0;

        // reset in the middle of F6; new start clears ovf
        ifc.mw_mf = 1'b1;
        ifc.fic_end = 1'b0;
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        chk("rs_ovf_clr", {ifc._0_f, ifc.ovf}, 2'b10);
        repeat (10) @(posedge clk);
        #1;
        chk("rs_in_f6", ph_code(), 6);
        #3;
        clr_ = 1'b0;
        #1;
        chk("rs_lines", {ifc.f2_, ifc.f4_, ifc.f5_, ifc.f6_, ifc.f7_,
                         ifc.f8_, ifc.f10_, ifc.f9, ifc.f13}, 9'h1FC);
        chk("rs_busy", {ifc.busy, ifc.done, ifc.abort}, 3'b000);
        @(posedge clk);
        #1;
        clr_ = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ifc.done || ifc.abort || ifc.busy) cnt++;
        end
        chk("rs_quiet", cnt, 0);
        run(1, 0, 1'b0, 1'b0, 200, tr, cyc, gd, ga, nclr, viol);
        chks("rs_restart", tr, "2,4,6,10,13,");
        chk("rs_restart_done", {gd, ga}, 2'b10);
        ifc.mw_mf = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
